// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 responder emulating a transceiver register interface.
// A header byte {rw, burst, addr[5:0]} selects a register read, a register write
// or (burst=0, addr >= STROBE_BASE) a command strobe. A 64x8 register file is
// served over the link, and each byte on miso is the status byte unless read
// data is being returned.
//
// Ports:
//   clk, rst             system clock (>= 8x sclk), synchronous active-high reset
//   sclk, ss, mosi       asynchronous SPI pins, synchronised internally
//   miso, miso_oe        serial data out (MSB first) and pad output enable
//   status_in            low nibble of the status byte
//   rx_byte, rx_valid    last complete byte and its 1-cycle pulse
//   wr_en, wr_addr,      1-cycle register-write pulse with its address/data
//   wr_data
//   strobe, strobe_addr  1-cycle command strobe pulse with its address
module spi_slave_regs #(
  parameter logic       CHIP_RDY_N_DEFAULT = 1'b0,
  parameter logic [5:0] STROBE_BASE        = 6'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [3:0] status_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       strobe,
  output logic [5:0] strobe_addr
);

  typedef enum logic [2:0] {IDLE, HEADER, WRITE, READ, DRAIN} state_t;

  state_t     state;
  logic       sclk_s1, sclk_s2, sclk_d;
  logic       ss_s1, ss_s2, ss_d;
  logic       mosi_s1, mosi_s2;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       burst;
  logic [5:0] addr;
  logic       chip_rdy_n;
  logic [7:0] regs [64];

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0] status_byte;
  logic [7:0] rx_next;
  logic [5:0] addr_inc;

  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign ss_rise     = ss_s2 & ~ss_d;
  assign ss_fall     = ~ss_s2 & ss_d;
  assign status_byte = {chip_rdy_n, 3'b000, status_in};
  assign rx_next     = {rx_shift, mosi_s2};
  assign addr_inc    = addr + 6'd1;

  // tx_shift is cleared whenever the slave is deselected, so miso idles low.
  assign miso = tx_shift[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      // ss synchronisers reset low: an ss already held low after reset
      // produces no falling edge and so starts no transaction.
      {sclk_s1, sclk_s2, sclk_d} <= '0;
      {ss_s1, ss_s2, ss_d}       <= '0;
      {mosi_s1, mosi_s2}         <= '0;
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      burst       <= 1'b0;
      addr        <= '0;
      chip_rdy_n  <= CHIP_RDY_N_DEFAULT;
      miso_oe     <= 1'b0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      strobe      <= 1'b0;
      strobe_addr <= '0;
      for (int unsigned i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      sclk_s1    <= sclk;
      sclk_s2    <= sclk_s1;
      sclk_d     <= sclk_s2;
      ss_s1      <= ss;
      ss_s2      <= ss_s1;
      ss_d       <= ss_s2;
      mosi_s1    <= mosi;
      mosi_s2    <= mosi_s1;
      chip_rdy_n <= 1'b0;
      rx_valid   <= 1'b0;
      wr_en      <= 1'b0;
      strobe     <= 1'b0;

      // Deselect takes priority over any byte completing in the same cycle.
      if (ss_rise) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        tx_shift <= '0;
        miso_oe  <= 1'b0;
      end else if (ss_fall) begin
        state    <= HEADER;
        bit_cnt  <= '0;
        tx_shift <= status_byte;
        miso_oe  <= 1'b1;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          rx_shift <= rx_next[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte  <= rx_next;
            rx_valid <= 1'b1;
            case (state)
              HEADER: begin
                burst <= rx_next[6];
                addr  <= rx_next[5:0];
                if (!rx_next[6] && (rx_next[5:0] >= STROBE_BASE)) begin
                  strobe      <= 1'b1;
                  strobe_addr <= rx_next[5:0];
                  tx_shift    <= status_byte;
                  state       <= DRAIN;
                end else if (rx_next[7]) begin
                  tx_shift <= regs[rx_next[5:0]];
                  state    <= READ;
                end else begin
                  tx_shift <= status_byte;
                  state    <= WRITE;
                end
              end
              WRITE: begin
                regs[addr] <= rx_next;
                wr_en      <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= rx_next;
                tx_shift   <= status_byte;
                if (burst) addr  <= addr_inc;
                else       state <= DRAIN;
              end
              READ: begin
                if (burst) begin
                  addr     <= addr_inc;
                  tx_shift <= regs[addr_inc];
                end else begin
                  tx_shift <= status_byte;
                  state    <= DRAIN;
                end
              end
              DRAIN:   tx_shift <= status_byte;
              default: state    <= IDLE;
            endcase
          end
        end else if (sclk_fall && (bit_cnt != 3'd0)) begin
          // At a byte boundary the next byte's MSB is already in place.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule
